// File: rtl/rb_arbiter.sv
// Two-requester (I2C / UART) arbiter in front of a register bank. Forwards the
// granted requester's strobes with one cycle of latency and tracks collisions.
module rb_arbiter #(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int RR_ENABLE      = 1
) (
   input  logic       clk,
   input  logic       resetb,
   input  logic [7:0] i2c_address,
   input  logic [7:0] i2c_data_write_to_reg,
   input  logic       i2c_reg_en,
   input  logic       i2c_write_en,
   input  logic [1:0] i2c_streamSt_mon,
   input  logic [7:0] uart_address,
   input  logic [7:0] uart_data_write_to_reg,
   input  logic       uart_reg_en,
   input  logic       uart_write_en,
   input  logic [1:0] uart_streamSt_mon,
   output logic [7:0] rb_address,
   output logic [7:0] rb_data_write_to_reg,
   output logic       rb_reg_en,
   output logic       rb_write_en,
   output logic [1:0] rb_streamSt_mon,
   output logic [1:0] grant_mon,
   input  logic       clr_status,
   output logic [7:0] collision_cnt,
   output logic       collision_flag,
   output logic       timeout_flag
);

   // Handshake: reg_en is a single-cycle strobe with no back-pressure; a strobe
   // is accepted only if its requester owns the bank on the following edge.
   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      GNT_I2C  = 2'b01,
      GNT_UART = 2'b10
   } state_t;

   localparam logic [15:0] HOLD_MAX = 16'(TIMEOUT_CYCLES - 1);

   state_t      state, next_state;
   logic        last_uart;
   logic        blk_i2c, blk_uart;
   logic [15:0] hold_cnt;
   logic        i2c_active, uart_active;
   logic        elig_i2c, elig_uart;
   logic        gnt_reg_en, timeout_hit, collision;

   assign grant_mon = state;

   always_comb begin
      i2c_active  = i2c_reg_en  || (i2c_streamSt_mon  != 2'b00);
      uart_active = uart_reg_en || (uart_streamSt_mon != 2'b00);
      elig_i2c    = i2c_active  && !blk_i2c;
      elig_uart   = uart_active && !blk_uart;
      next_state  = state;
      gnt_reg_en  = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (elig_i2c && elig_uart)
               next_state = ((RR_ENABLE != 0) && last_uart) ? GNT_I2C : GNT_UART;
            else if (elig_i2c)
               next_state = GNT_I2C;
            else if (elig_uart)
               next_state = GNT_UART;
         end
         GNT_I2C: begin
            gnt_reg_en = i2c_reg_en;
            if (!i2c_active)
               next_state = IDLE;
            else if ((hold_cnt == HOLD_MAX) && !i2c_reg_en) begin
               timeout_hit = 1'b1;
               next_state  = IDLE;
            end
         end
         GNT_UART: begin
            gnt_reg_en = uart_reg_en;
            if (!uart_active)
               next_state = IDLE;
            else if ((hold_cnt == HOLD_MAX) && !uart_reg_en) begin
               timeout_hit = 1'b1;
               next_state  = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
      // Any strobe whose owner does not hold the bank next cycle is lost.
      collision = (i2c_reg_en  && (next_state != GNT_I2C)) ||
                  (uart_reg_en && (next_state != GNT_UART));
   end

   always_ff @(posedge clk) begin
      if (!resetb) begin
         state                <= IDLE;
         last_uart            <= 1'b0;
         blk_i2c              <= 1'b0;
         blk_uart             <= 1'b0;
         hold_cnt             <= '0;
         rb_address           <= '0;
         rb_data_write_to_reg <= '0;
         rb_reg_en            <= 1'b0;
         rb_write_en          <= 1'b0;
         rb_streamSt_mon      <= '0;
         collision_cnt        <= '0;
         collision_flag       <= 1'b0;
         timeout_flag         <= 1'b0;
      end else begin
         state <= next_state;
         if ((state == IDLE) && (next_state != IDLE))
            last_uart <= (next_state == GNT_UART);
         blk_i2c  <= (timeout_hit && (state == GNT_I2C))  || (blk_i2c  && i2c_active);
         blk_uart <= (timeout_hit && (state == GNT_UART)) || (blk_uart && uart_active);
         if ((state == IDLE) || (next_state == IDLE) || gnt_reg_en)
            hold_cnt <= '0;
         else
            hold_cnt <= hold_cnt + 16'd1;

         // Forward from the next owner so the deciding cycle's strobe is kept.
         case (next_state)
            GNT_I2C: begin
               rb_address           <= i2c_address;
               rb_data_write_to_reg <= i2c_data_write_to_reg;
               rb_reg_en            <= i2c_reg_en;
               rb_write_en          <= i2c_write_en & i2c_reg_en;
               rb_streamSt_mon      <= i2c_streamSt_mon;
            end
            GNT_UART: begin
               rb_address           <= uart_address;
               rb_data_write_to_reg <= uart_data_write_to_reg;
               rb_reg_en            <= uart_reg_en;
               rb_write_en          <= uart_write_en & uart_reg_en;
               rb_streamSt_mon      <= uart_streamSt_mon;
            end
            default: begin
               rb_address           <= '0;
               rb_data_write_to_reg <= '0;
               rb_reg_en            <= 1'b0;
               rb_write_en          <= 1'b0;
               rb_streamSt_mon      <= '0;
            end
         endcase

         if (collision) begin
            collision_flag <= 1'b1;
            if (clr_status)
               collision_cnt <= 8'd1;
            else if (collision_cnt != 8'hFF)
               collision_cnt <= collision_cnt + 8'd1;
         end else if (clr_status) begin
            collision_flag <= 1'b0;
            collision_cnt  <= '0;
         end

         if (timeout_hit)
            timeout_flag <= 1'b1;
         else if (clr_status)
            timeout_flag <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rb_arbiter.sv
// Directed bench for rb_arbiter: grants, round-robin vs fixed priority,
// collisions with saturation, hold timeout with re-grant blocking, and reset.
module tb_rb_arbiter;

   logic       clk = 1'b0;
   logic       resetb = 1'b0;
   logic [7:0] i2c_address = '0, i2c_data_write_to_reg = '0;
   logic       i2c_reg_en = 1'b0, i2c_write_en = 1'b0;
   logic [1:0] i2c_streamSt_mon = '0;
   logic [7:0] uart_address = '0, uart_data_write_to_reg = '0;
   logic       uart_reg_en = 1'b0, uart_write_en = 1'b0;
   logic [1:0] uart_streamSt_mon = '0;
   logic       clr_status = 1'b0;

   logic [7:0] rb_address, rb_data_write_to_reg, collision_cnt;
   logic       rb_reg_en, rb_write_en, collision_flag, timeout_flag;
   logic [1:0] rb_streamSt_mon, grant_mon;

   logic [7:0] rb_address_f, rb_data_f, collision_cnt_f;
   logic       rb_reg_en_f, rb_write_en_f, collision_flag_f, timeout_flag_f;
   logic [1:0] rb_stream_f, grant_mon_f;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   rb_arbiter #(.TIMEOUT_CYCLES(16), .RR_ENABLE(1)) dut (
      .clk(clk), .resetb(resetb),
      .i2c_address(i2c_address), .i2c_data_write_to_reg(i2c_data_write_to_reg),
      .i2c_reg_en(i2c_reg_en), .i2c_write_en(i2c_write_en), .i2c_streamSt_mon(i2c_streamSt_mon),
      .uart_address(uart_address), .uart_data_write_to_reg(uart_data_write_to_reg),
      .uart_reg_en(uart_reg_en), .uart_write_en(uart_write_en), .uart_streamSt_mon(uart_streamSt_mon),
      .rb_address(rb_address), .rb_data_write_to_reg(rb_data_write_to_reg),
      .rb_reg_en(rb_reg_en), .rb_write_en(rb_write_en), .rb_streamSt_mon(rb_streamSt_mon),
      .grant_mon(grant_mon), .clr_status(clr_status), .collision_cnt(collision_cnt),
      .collision_flag(collision_flag), .timeout_flag(timeout_flag)
   );

   rb_arbiter #(.RR_ENABLE(0)) dut_f (
      .clk(clk), .resetb(resetb),
      .i2c_address(i2c_address), .i2c_data_write_to_reg(i2c_data_write_to_reg),
      .i2c_reg_en(i2c_reg_en), .i2c_write_en(i2c_write_en), .i2c_streamSt_mon(i2c_streamSt_mon),
      .uart_address(uart_address), .uart_data_write_to_reg(uart_data_write_to_reg),
      .uart_reg_en(uart_reg_en), .uart_write_en(uart_write_en), .uart_streamSt_mon(uart_streamSt_mon),
      .rb_address(rb_address_f), .rb_data_write_to_reg(rb_data_f),
      .rb_reg_en(rb_reg_en_f), .rb_write_en(rb_write_en_f), .rb_streamSt_mon(rb_stream_f),
      .grant_mon(grant_mon_f), .clr_status(clr_status), .collision_cnt(collision_cnt_f),
      .collision_flag(collision_flag_f), .timeout_flag(timeout_flag_f)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Advance one rising edge and settle; outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i2c_address = '0; i2c_data_write_to_reg = '0; i2c_reg_en = 1'b0;
      i2c_write_en = 1'b0; i2c_streamSt_mon = '0;
      uart_address = '0; uart_data_write_to_reg = '0; uart_reg_en = 1'b0;
      uart_write_en = 1'b0; uart_streamSt_mon = '0;
      clr_status = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      resetb = 1'b0;
      tick();
      tick();
      resetb = 1'b1;
   endtask

   initial begin
      #1;
      // Reset state
      do_reset();
      check("rst_grant", 16'(grant_mon), 16'h0);
      check("rst_grant_f", 16'(grant_mon_f), 16'h0);
      check("rst_addr", 16'(rb_address), 16'h0);
      check("rst_data", 16'(rb_data_write_to_reg), 16'h0);
      check("rst_reg_en", 16'(rb_reg_en), 16'h0);
      check("rst_we", 16'(rb_write_en), 16'h0);
      check("rst_stream", 16'(rb_streamSt_mon), 16'h0);
      check("rst_cnt", 16'(collision_cnt), 16'h0);
      check("rst_cflag", 16'(collision_flag), 16'h0);
      check("rst_tflag", 16'(timeout_flag), 16'h0);

      // UART-only write, first strobe forwarded
      uart_address = 8'h05; uart_data_write_to_reg = 8'h80;
      uart_reg_en = 1'b1; uart_write_en = 1'b1;
      tick();
      check("uw_grant", 16'(grant_mon), 16'h2);
      check("uw_addr", 16'(rb_address), 16'h05);
      check("uw_data", 16'(rb_data_write_to_reg), 16'h80);
      check("uw_reg_en", 16'(rb_reg_en), 16'h1);
      check("uw_we", 16'(rb_write_en), 16'h1);
      idle_inputs();
      tick();
      check("uw_exit_grant", 16'(grant_mon), 16'h0);
      check("uw_exit_reg_en", 16'(rb_reg_en), 16'h0);
      check("uw_exit_addr", 16'(rb_address), 16'h0);

      // write_en without reg_en must not produce rb_write_en
      i2c_streamSt_mon = 2'b01; i2c_write_en = 1'b1; i2c_address = 8'h22;
      tick();
      check("we_and_grant", 16'(grant_mon), 16'h1);
      check("we_and_we", 16'(rb_write_en), 16'h0);
      check("we_and_stream", 16'(rb_streamSt_mon), 16'h1);
      check("we_and_addr", 16'(rb_address), 16'h22);
      idle_inputs();
      tick();

      // Simultaneous activity: RR alternates, fixed priority always UART
      do_reset();
      i2c_streamSt_mon = 2'b01; uart_streamSt_mon = 2'b11;
      tick();
      check("rr1_grant", 16'(grant_mon), 16'h2);
      check("rr1_stream", 16'(rb_streamSt_mon), 16'h3);
      check("fix1_grant", 16'(grant_mon_f), 16'h2);
      idle_inputs();
      tick();
      check("rr_rel_grant", 16'(grant_mon), 16'h0);
      check("rr_rel_stream", 16'(rb_streamSt_mon), 16'h0);
      i2c_streamSt_mon = 2'b01; uart_streamSt_mon = 2'b11;
      tick();
      check("rr2_grant", 16'(grant_mon), 16'h1);
      check("rr2_stream", 16'(rb_streamSt_mon), 16'h1);
      check("fix2_grant", 16'(grant_mon_f), 16'h2);
      idle_inputs();
      tick();

      // Collisions while I2C owns the bank
      i2c_streamSt_mon = 2'b01;
      tick();
      check("col_grant", 16'(grant_mon), 16'h1);
      for (int i = 0; i < 3; i++) begin
         uart_reg_en = 1'b1; uart_address = 8'h77;
         tick();
         check("col_no_fwd", 16'(rb_reg_en), 16'h0);
         uart_reg_en = 1'b0;
         tick();
      end
      check("col_cnt3", 16'(collision_cnt), 16'h3);
      check("col_flag", 16'(collision_flag), 16'h1);
      check("col_grant_kept", 16'(grant_mon), 16'h1);
      i2c_address = 8'h3C; i2c_data_write_to_reg = 8'hA5; i2c_reg_en = 1'b1; i2c_write_en = 1'b1;
      tick();
      check("i2c_wr_addr", 16'(rb_address), 16'h3C);
      check("i2c_wr_data", 16'(rb_data_write_to_reg), 16'hA5);
      check("i2c_wr_we", 16'(rb_write_en), 16'h1);
      i2c_reg_en = 1'b0; i2c_write_en = 1'b0;
      clr_status = 1'b1;
      tick();
      clr_status = 1'b0;
      check("clr_cnt", 16'(collision_cnt), 16'h0);
      check("clr_flag", 16'(collision_flag), 16'h0);
      clr_status = 1'b1; uart_reg_en = 1'b1;
      tick();
      clr_status = 1'b0; uart_reg_en = 1'b0;
      check("clr_prec_cnt", 16'(collision_cnt), 16'h1);
      check("clr_prec_flag", 16'(collision_flag), 16'h1);
      clr_status = 1'b1;
      tick();
      clr_status = 1'b0;

      // Saturation: I2C keeps strobing (no timeout), UART collides every cycle
      i2c_reg_en = 1'b1; uart_reg_en = 1'b1;
      for (int i = 0; i < 254; i++) tick();
      check("sat_254", 16'(collision_cnt), 16'd254);
      for (int i = 0; i < 46; i++) tick();
      check("sat_255", 16'(collision_cnt), 16'd255);
      check("sat_grant", 16'(grant_mon), 16'h1);
      check("sat_fwd", 16'(rb_reg_en), 16'h1);
      idle_inputs();
      clr_status = 1'b1;
      tick();
      clr_status = 1'b0;
      check("sat_clr", 16'(collision_cnt), 16'h0);
      check("sat_idle", 16'(grant_mon), 16'h0);

      // Hold timeout (TIMEOUT_CYCLES = 16) and re-grant blocking
      i2c_streamSt_mon = 2'b01;
      tick();
      check("to_grant", 16'(grant_mon), 16'h1);
      for (int i = 0; i < 15; i++) tick();
      check("to_before", 16'(grant_mon), 16'h1);
      check("to_flag_before", 16'(timeout_flag), 16'h0);
      tick();
      check("to_release", 16'(grant_mon), 16'h0);
      check("to_flag", 16'(timeout_flag), 16'h1);
      check("to_stream", 16'(rb_streamSt_mon), 16'h0);
      for (int i = 0; i < 3; i++) tick();
      check("to_blocked", 16'(grant_mon), 16'h0);
      i2c_streamSt_mon = 2'b00;
      tick();
      check("to_unblock_idle", 16'(grant_mon), 16'h0);
      i2c_streamSt_mon = 2'b01;
      tick();
      check("to_regrant", 16'(grant_mon), 16'h1);
      idle_inputs();
      clr_status = 1'b1;
      tick();
      clr_status = 1'b0;
      check("to_clr", 16'(timeout_flag), 16'h0);

      // Reset mid-grant while UART streams
      uart_streamSt_mon = 2'b10; uart_reg_en = 1'b1; uart_address = 8'h40;
      tick();
      check("mr_grant", 16'(grant_mon), 16'h2);
      check("mr_reg_en", 16'(rb_reg_en), 16'h1);
      resetb = 1'b0;
      tick();
      check("mr_rst_grant", 16'(grant_mon), 16'h0);
      check("mr_rst_reg_en", 16'(rb_reg_en), 16'h0);
      check("mr_rst_addr", 16'(rb_address), 16'h0);
      check("mr_rst_stream", 16'(rb_streamSt_mon), 16'h0);
      resetb = 1'b1;
      tick();
      check("mr_restart", 16'(grant_mon), 16'h2);
      idle_inputs();
      tick();
      check("mr_end_idle", 16'(grant_mon), 16'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
